nibble_prog_loader: RTL and testbench

- Writer side of the Nibbler program memory. The core only reads program bytes by PC; this block fills that memory from a 4-bit nibble stream, for example from a host link or a bench.
- It holds the core in reset while loading, then releases it so the core starts executing from address 0.
- It sits between the external load stream, the program memory write port and the core reset input.

---
 rtl/nibble_prog_loader_pkg.sv | 12 +
 rtl/nibble_prog_loader_if.sv | 23 ++
 rtl/nibble_pair_assembler.sv | 60 ++++++
 rtl/nibble_prog_loader.sv | 174 +++++++++++++++++
 tb/tb_nibble_prog_loader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_prog_loader_pkg.sv
// Shared types and widths for the Nibbler program loader.
package nibble_pkg;
   localparam int NIB_W       = 4;
   localparam int BYTE_W      = 8;
   localparam int ADDR_W      = 12;
   localparam int LEN_NIBBLES = 3;
   localparam int LEN_W       = LEN_NIBBLES * NIB_W;

   typedef enum logic [3:0] {
      IDLE, LEN0, LEN1, LEN2, HI, LO, WR, CHK, FIN
   } state_t;
endpackage

// File: rtl/nibble_prog_loader_if.sv
// Nibble load stream plus program-memory write port.
// The master drives the stream; the slave (the loader) drives ready and the write port.
interface nibble_prog_loader_if #(
   parameter int ADDR_W = nibble_pkg::ADDR_W,
   parameter int BYTE_W = nibble_pkg::BYTE_W
);
   logic                         in_valid;
   logic [nibble_pkg::NIB_W-1:0] in_data;
   logic                         in_ready;
   logic                         prog_we;
   logic [ADDR_W-1:0]            prog_addr;
   logic [BYTE_W-1:0]            prog_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, prog_we, prog_addr, prog_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, prog_we, prog_addr, prog_wdata
   );
endinterface

// File: rtl/nibble_pair_assembler.sv
// Packs high/low nibbles into a program byte; keeps the running 4-bit
// frame checksum when NIBBLE_LOADER_CHECKSUM_EN is defined.
module nibble_pair_assembler
   import nibble_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
`ifdef NIBBLE_LOADER_CHECKSUM_EN
   input  logic              clr,
   input  logic              ld_len,
   output logic [NIB_W-1:0]  csum,
`endif
   input  logic              ld_hi,
   input  logic              ld_lo,
   input  logic [NIB_W-1:0]  nib,
   output logic [BYTE_W-1:0] byte_o
);

   logic [NIB_W-1:0] hi_q, hi_d;
   logic [NIB_W-1:0] lo_q, lo_d;

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (ld_hi) hi_d = nib;
      if (ld_lo) lo_d = nib;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign byte_o = {hi_q, lo_q};

`ifdef NIBBLE_LOADER_CHECKSUM_EN
   logic [NIB_W-1:0] csum_q, csum_d;

   // Modulo-16 sum of every length and data nibble; wraps naturally.
   always_comb begin
      csum_d = csum_q;
      if (clr)
         csum_d = '0;
      else if (ld_len || ld_hi || ld_lo)
         csum_d = csum_q + nib;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) csum_q <= '0;
      else        csum_q <= csum_d;
   end

   assign csum = csum_q;
`endif
endmodule

// File: rtl/nibble_prog_loader.sv
// Fills the Nibbler program memory from a nibble stream and holds the core in
// reset while loading. Optional frame checksum: NIBBLE_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start; core_hold keeps its last value
// LEN0  | length nibble 2 (MSB)
// LEN1  | length nibble 1
// LEN2  | length nibble 0 (LSB); zero length skips data
// HI    | high nibble of the next byte
// LO    | low nibble of the next byte
// WR    | program write cycle, stream stalled
// CHK   | checksum nibble (checksum build only)
// FIN   | done pulse, core released
module nibble_prog_loader #(
   parameter int                ADDR_W    = nibble_pkg::ADDR_W,
   parameter int                BYTE_W    = nibble_pkg::BYTE_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   nibble_prog_loader_if.slave        bus,
   output logic                       core_hold,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);
   import nibble_pkg::*;

`ifdef NIBBLE_LOADER_CHECKSUM_EN
   localparam state_t LAST_ST = CHK;
`else
   localparam state_t LAST_ST = FIN;
`endif

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              core_hold_q, core_hold_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              accept;
   logic              ld_hi, ld_lo;
   logic [BYTE_W-1:0] pair_byte;
`ifdef NIBBLE_LOADER_CHECKSUM_EN
   logic              csum_clr, ld_len;
   logic [NIB_W-1:0]  csum;
`endif

   assign accept = bus.in_valid && in_ready_q;

   always_comb begin
      state_d     = state_q;
      core_hold_d = core_hold_q;
      busy_d      = busy_q;
      err_d       = err_q;
      len_d       = len_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      ld_hi       = 1'b0;
      ld_lo       = 1'b0;
`ifdef NIBBLE_LOADER_CHECKSUM_EN
      csum_clr    = 1'b0;
      ld_len      = 1'b0;
`endif
      // abort beats acceptance; core stays held because the image is partial
      if (state_q != IDLE && abort) begin
         state_d = IDLE;
         err_d   = 1'b1;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_d     = LEN0;
               core_hold_d = 1'b1;
               busy_d      = 1'b1;
               err_d       = 1'b0;
               len_d       = '0;
               idx_d       = '0;
`ifdef NIBBLE_LOADER_CHECKSUM_EN
               csum_clr    = 1'b1;
`endif
            end
            LEN0, LEN1, LEN2: if (accept) begin
               len_d = {len_q[LEN_W-NIB_W-1:0], bus.in_data};
`ifdef NIBBLE_LOADER_CHECKSUM_EN
               ld_len = 1'b1;
`endif
               if (state_q == LEN0)      state_d = LEN1;
               else if (state_q == LEN1) state_d = LEN2;
               else                      state_d = (len_d == '0) ? LAST_ST : HI;
            end
            HI: if (accept) begin
               ld_hi   = 1'b1;
               state_d = LO;
            end
            LO: if (accept) begin
               ld_lo   = 1'b1;
               addr_d  = BASE_ADDR + ADDR_W'(idx_q);
               idx_d   = idx_q + 1'b1;
               state_d = WR;
            end
            WR: state_d = (idx_q == len_q) ? LAST_ST : HI;
`ifdef NIBBLE_LOADER_CHECKSUM_EN
            CHK: if (accept) begin
               if (bus.in_data == csum) begin
                  state_d = FIN;
               end else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
               end
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
         // FIN always exits next cycle, so state_d==FIN only on entry
         if (state_d == FIN) begin
            core_hold_d = 1'b0;
            busy_d      = 1'b0;
         end
      end
      in_ready_d = state_d inside {LEN0, LEN1, LEN2, HI, LO, CHK};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         core_hold_q <= 1'b1;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         len_q       <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         core_hold_q <= core_hold_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
      end
   end

   nibble_pair_assembler u_pair (
      .clk    (clk),
      .reset  (reset),
`ifdef NIBBLE_LOADER_CHECKSUM_EN
      .clr    (csum_clr),
      .ld_len (ld_len),
      .csum   (csum),
`endif
      .ld_hi  (ld_hi),
      .ld_lo  (ld_lo),
      .nib    (bus.in_data),
      .byte_o (pair_byte)
   );

   assign bus.in_ready   = in_ready_q;
   assign bus.prog_we    = (state_q == WR) && !abort;
   assign bus.prog_addr  = addr_q;
   assign bus.prog_wdata = pair_byte;
   assign core_hold      = core_hold_q;
   assign busy           = busy_q;
   assign done           = (state_q == FIN);
   assign err            = err_q;
endmodule

// File: tb/tb_nibble_prog_loader.sv
// Bench for nibble_prog_loader: two instances (base 000 and FFF) share one
// stream; expected writes are queued when driven and popped on prog_we.
module tb_nibble_prog_loader;
   typedef struct {
      logic [11:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic clk, reset, start, abort;
   logic hold_a, busy_a, done_a, err_a;
   logic hold_b, busy_b, done_b, err_b;
   int   n_chk, n_fail;
   wr_t  qa[$], qb[$];
   wr_t  ea, eb;
   logic [7:0] frm[$];
`ifdef NIBBLE_LOADER_CHECKSUM_EN
   bit   bad_ck;
`endif

   nibble_prog_loader_if ifa ();
   nibble_prog_loader_if ifb ();

   assign ifb.in_valid = ifa.in_valid;
   assign ifb.in_data  = ifa.in_data;

   nibble_prog_loader #(.BASE_ADDR(12'h000)) dut_a (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .bus(ifa),
      .core_hold(hold_a), .busy(busy_a), .done(done_a), .err(err_a)
   );

   nibble_prog_loader #(.BASE_ADDR(12'hFFF)) dut_b (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .bus(ifb),
      .core_hold(hold_b), .busy(busy_b), .done(done_b), .err(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ifa.prog_we) begin
         if (qa.size() == 0) chk("a_unexpected_we", 1, 0);
         else begin
            ea = qa.pop_front();
            chk("a_addr", 32'(ifa.prog_addr), 32'(ea.addr));
            chk("a_data", 32'(ifa.prog_wdata), 32'(ea.data));
         end
      end
      if (ifb.prog_we) begin
         if (qb.size() == 0) chk("b_unexpected_we", 1, 0);
         else begin
            eb = qb.pop_front();
            chk("b_addr", 32'(ifb.prog_addr), 32'(eb.addr));
            chk("b_data", 32'(ifb.prog_wdata), 32'(eb.data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_nib(input logic [3:0] nib);
      int budget;
      budget = 50;
      ifa.in_valid = 1'b1;
      ifa.in_data  = nib;
      while (!ifa.in_ready && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) chk("ready_timeout", 0, 1);
      tick();
      ifa.in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Sends a whole frame using frm[] as data and checks the frame end.
   task automatic send_frame(input bit stall, input bit extra_start);
      logic [11:0] len;
      logic [3:0]  sum;
      len = 12'(frm.size());
      sum = '0;
      pulse_start();
      chk("start_busy", busy_a, 1);
      chk("start_err", err_a, 0);
      chk("start_hold", hold_a, 1);
      for (int i = 2; i >= 0; i--) begin
         sum += len[i*4 +: 4];
         if (stall) tick();
         send_nib(len[i*4 +: 4]);
      end
      for (int i = 0; i < frm.size(); i++) begin
         qa.push_back('{addr: 12'(i), data: frm[i]});
         qb.push_back('{addr: 12'hFFF + 12'(i), data: frm[i]});
         if (extra_start && i == 1) begin
            pulse_start();
            chk("extra_start_busy", busy_a, 1);
         end
         sum += frm[i][7:4] + frm[i][3:0];
         if (stall) tick();
         send_nib(frm[i][7:4]);
         if (stall) tick();
         send_nib(frm[i][3:0]);
      end
`ifdef NIBBLE_LOADER_CHECKSUM_EN
      if (frm.size() != 0) tick();
      send_nib(bad_ck ? sum + 4'd1 : sum);
      if (bad_ck) begin
         chk("ck_bad_done", done_a, 0);
         chk("ck_bad_err", err_a, 1);
         chk("ck_bad_hold", hold_a, 1);
         chk("ck_bad_busy", busy_a, 0);
         return;
      end
`else
      if (sum == 4'hF) n_chk += 0;
      if (frm.size() != 0) tick();
`endif
      chk("fin_done_a", done_a, 1);
      chk("fin_done_b", done_b, 1);
      chk("fin_hold", hold_a, 0);
      chk("fin_err", err_a, 0);
      chk("fin_busy", busy_a, 0);
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      tick();
      chk("done_one_cycle", done_a, 0);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      ifa.in_valid = 1'b0; ifa.in_data = '0;
`ifdef NIBBLE_LOADER_CHECKSUM_EN
      bad_ck = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_hold", hold_a, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_ready", ifa.in_ready, 0);
      chk("rst_we", ifa.prog_we, 0);
      chk("rst_addr_b", 32'(ifb.prog_addr), 0);
      chk("rst_wdata", 32'(ifa.prog_wdata), 0);
      reset = 1'b1;
      tick();

      // basic two-byte frame; instance b wraps FFF -> 000
      frm = {8'hA5, 8'h3C};
      send_frame(1'b0, 1'b0);

      // zero-length frame
      frm = {};
      send_frame(1'b0, 1'b0);

      // abort on the low nibble of byte 1: no write
      pulse_start();
      send_nib(4'h0); send_nib(4'h0); send_nib(4'h2);
      send_nib(4'hA);
      ifa.in_valid = 1'b1; ifa.in_data = 4'h5; abort = 1'b1;
      tick();
      abort = 1'b0; ifa.in_valid = 1'b0;
      chk("abort_busy", busy_a, 0);
      chk("abort_err", err_a, 1);
      chk("abort_hold", hold_a, 1);
      chk("abort_ready", ifa.in_ready, 0);
      repeat (3) tick();
      chk("abort_err_sticky", err_a, 1);

      // abort during the write cycle suppresses prog_we
      pulse_start();
      chk("restart_err_clr", err_a, 0);
      send_nib(4'h0); send_nib(4'h0); send_nib(4'h1);
      send_nib(4'h7); send_nib(4'h7);
      abort = 1'b1;
      @(negedge clk);
      chk("abort_wr_we", ifa.prog_we, 0);
      tick();
      abort = 1'b0;
      chk("abort_wr_err", err_a, 1);
      chk("abort_wr_hold", hold_a, 1);

      // start and abort together in IDLE: start wins
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", busy_a, 1);
      chk("start_abort_err", err_a, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // stalled stream with a stray start: same writes as unstalled
      frm = {8'h11, 8'h22, 8'h33};
      send_frame(1'b1, 1'b1);
      frm = {8'h11, 8'h22, 8'h33};
      send_frame(1'b0, 1'b0);

      // random bytes
      frm = {};
      for (int i = 0; i < 5; i++) frm.push_back(8'($urandom_range(0, 255)));
      send_frame(1'b0, 1'b0);

`ifdef NIBBLE_LOADER_CHECKSUM_EN
      frm = {8'hFF};
      send_frame(1'b0, 1'b0);
      bad_ck = 1'b1;
      frm = {8'hFF};
      send_frame(1'b0, 1'b0);
      bad_ck = 1'b0;
      chk("ck_bad_no_done", done_a, 0);
`endif

      // reset mid-frame
      pulse_start();
      send_nib(4'h0); send_nib(4'h0);
      reset = 1'b0;
      #1;
      chk("midrst_hold", hold_a, 1);
      chk("midrst_err", err_a, 0);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_ready", ifa.in_ready, 0);
      tick();
      reset = 1'b1;
      repeat (2) tick();
      chk("q_final_a", qa.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
